data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 Parameter SETS, default 32, number of direct-mapped one-word lines; power of two.
REQ-004 Port clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst_i  in  1  synchronous, active-high reset.
REQ-006 Port alu_resultM_i  in  ADDRESS_WIDTH  memory-stage byte address.
REQ-007 Port write_dataM_i  in  DATA_WIDTH  memory-stage store data.
REQ-008 Port mem_writeM_i  in  1  store request.
REQ-009 Port mem_readM_i  in  1  load request.
REQ-010 Port cache_weM_i  in  1  cacheable access; 0 means bypass.
REQ-011 Port read_dataM_o  out  DATA_WIDTH  load result.
REQ-012 Port stall_o  out  1  hold memory stage and all earlier stages.
REQ-013 Ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out ADDRESS_WIDTH, mem_wdata_o out DATA_WIDTH  backing-memory request.
REQ-014 Ports mem_ack_i in 1, mem_rdata_i in DATA_WIDTH  backing-memory completion.

Function
REQ-015 Address split: bits [1:0] ignored, index = next log2(SETS) bits, tag = remaining upper bits.
REQ-016 Hit = cache_weM_i, valid[index] and tag match; a cacheable load hit returns data combinationally with stall_o=0 (zero added latency).
REQ-017 FSM states IDLE, BUSY; IDLE->BUSY on any access needing memory; BUSY->IDLE on mem_ack_i; BUSY holds otherwise.
REQ-018 Access needing memory: load miss, uncached load, or any store (write-through).
REQ-019 Detection cycle (IDLE): stall_o=1 combinationally, mem_req_o=0; request fields registered at that edge.
REQ-020 In BUSY: mem_req_o=1; mem_we_o, mem_addr_o (word-aligned, [1:0]=0), mem_wdata_o held constant until ack.
REQ-021 stall_o = (IDLE and access needing memory) or (BUSY and not mem_ack_i).
REQ-022 Ack cycle: stall_o=0, load returns mem_rdata_i on read_dataM_o; pipeline advances at that edge.
REQ-023 Cacheable load miss: on ack edge write data, tag, valid=1 at index.
REQ-024 Store hit: update line data on ack edge; store miss: no allocate; uncached access never touches the array.
REQ-025 mem_readM_i and mem_writeM_i both high: treated as store only.
REQ-026 mem_ack_i while IDLE ignored; read_dataM_o = 0 when no load is active.
REQ-027 Optional hit/miss counters excluded; no other state.

Reset
REQ-028 rst_i high at an edge: FSM->IDLE, all valid bits cleared, registered request cleared; mem_req_o=0 next cycle.
REQ-029 Reset during BUSY abandons the transaction; a late mem_ack_i after reset has no effect.
REQ-030 Data and tag arrays need no reset.

Structure
REQ-031 Package cache_pkg holds state enum (IDLE, BUSY), SETS default, index/tag width constants.
REQ-032 One sub-module cache_ram: tag/valid/data arrays, asynchronous read, synchronous write, synchronous valid clear.

Verification
REQ-033 After reset, load 0x0000_0040 cacheable -> stall 1 cycle IDLE + BUSY until ack; mem_rdata 0xDEADBEEF, 3-cycle ack -> read_dataM_o 0xDEADBEEF on ack, stall drops.
REQ-034 Repeat load 0x0000_0040 -> hit, stall_o=0, 0xDEADBEEF same cycle, no mem_req_o.
REQ-035 Store 0x12345678 to 0x0000_0040 -> mem_we_o=1, addr 0x40 until ack; following load hits with 0x12345678.
REQ-036 Load 0x0000_00C0 (same index, SETS=32, different tag) -> miss, refill evicts; then load 0x40 misses.
REQ-037 Uncached load 0x0000_0080 with cache_weM_i=0 twice -> two memory requests, array unchanged.
REQ-038 rst_i asserted in BUSY before ack -> mem_req_o 0 next cycle, stall_o 0, prior lines invalid, late ack ignored.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the direct-mapped write-through data cache.
//   state_e        : controller state (IDLE / BUSY)
//   CACHE_SETS     : default number of one-word lines
//   CACHE_ADDR_W   : default byte-address width
//   BYTE_OFFSET_W  : byte-within-word address bits, ignored by the cache
//   CACHE_INDEX_W  : index width for the default geometry
//   CACHE_TAG_W    : tag width for the default geometry
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int CACHE_SETS    = 32;
    localparam int CACHE_ADDR_W  = 32;
    localparam int BYTE_OFFSET_W = 2;
    localparam int CACHE_INDEX_W = $clog2(CACHE_SETS);
    localparam int CACHE_TAG_W   = CACHE_ADDR_W - CACHE_INDEX_W - BYTE_OFFSET_W;

endpackage

// File: rtl/cache_ram.sv
// -----------------------------------------------------------------------------
// cache_ram
// Tag, valid and data storage for the direct-mapped cache.
//   clk_i                  : clock, writes on rising edge
//   rst_i                  : synchronous active-high clear of all valid bits
//   i_rd_index             : read index (asynchronous read)
//   o_rd_valid/o_rd_tag/o_rd_data : contents of the addressed line
//   i_wr_en                : write one line (tag + data) and mark it valid
//   i_wr_index/i_wr_tag/i_wr_data : write address and contents
// Tag and data arrays carry no reset; only the valid bits do.
// -----------------------------------------------------------------------------
module cache_ram
    import cache_pkg::*;
#(
    parameter int SETS       = CACHE_SETS,
    parameter int INDEX_W    = CACHE_INDEX_W,
    parameter int TAG_W      = CACHE_TAG_W,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_W-1:0]    i_wr_index,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [DATA_WIDTH-1:0] i_wr_data
);

    logic [SETS-1:0]       r_valid;
    logic [TAG_W-1:0]      r_tag  [SETS];
    logic [DATA_WIDTH-1:0] r_data [SETS];

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

    // Valid bits: cleared by reset, set by any line write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Tag and data arrays: plain synchronous write, no reset.
    always_ff @(posedge clk_i) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data
// cache sitting in the memory stage of a pipeline.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   alu_resultM_i           : byte address of the memory-stage access
//   write_dataM_i           : store data
//   mem_writeM_i/mem_readM_i: store / load request (both high => store)
//   cache_weM_i             : 1 = cacheable, 0 = bypass the array
//   read_dataM_o            : load result (0 when no load completes)
//   stall_o                 : freeze memory stage and everything before it
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : backing-memory request
//   mem_ack_i/mem_rdata_i   : backing-memory completion
// Load hits complete in the same cycle. Misses, uncached loads and every store
// take one detection cycle in IDLE, then wait in BUSY for mem_ack_i.
// -----------------------------------------------------------------------------
module data_cache
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = CACHE_SETS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] alu_resultM_i,
    input  logic [DATA_WIDTH-1:0]    write_dataM_i,
    input  logic                     mem_writeM_i,
    input  logic                     mem_readM_i,
    input  logic                     cache_weM_i,
    output logic [DATA_WIDTH-1:0]    read_dataM_o,
    output logic                     stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic                     mem_ack_i,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = ADDRESS_WIDTH - INDEX_W - BYTE_OFFSET_W;

    // Address decomposition of the current memory-stage access
    logic [INDEX_W-1:0]    w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_unused_byte_offset;

    // Array read port
    logic                  w_rd_valid;
    logic [TAG_W-1:0]      w_rd_tag;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Access classification
    logic                  w_is_store;
    logic                  w_is_load;
    logic                  w_hit;
    logic                  w_need_mem;

    // Array write port
    logic                  w_ack;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // Combinational outputs
    logic                  w_stall;
    logic [DATA_WIDTH-1:0] w_read_data;

    // Controller state and the request captured at the detection edge
    state_e                   r_state;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_wdata;
    logic                     r_is_load;
    logic                     r_cacheable;
    logic                     r_store_hit;
    logic [INDEX_W-1:0]       r_index;
    logic [TAG_W-1:0]         r_tag;

    assign w_index              = alu_resultM_i[INDEX_W+BYTE_OFFSET_W-1:BYTE_OFFSET_W];
    assign w_tag                = alu_resultM_i[ADDRESS_WIDTH-1:INDEX_W+BYTE_OFFSET_W];
    assign w_unused_byte_offset = ^alu_resultM_i[BYTE_OFFSET_W-1:0];

    // A simultaneous read+write request is a store.
    assign w_is_store = mem_writeM_i;
    assign w_is_load  = mem_readM_i & ~mem_writeM_i;
    assign w_hit      = cache_weM_i & w_rd_valid & (w_rd_tag == w_tag);
    assign w_need_mem = w_is_store | (w_is_load & ~w_hit);

    // The array only changes when a transaction completes: a cacheable load
    // refills its line, a store that hit at detection refreshes its line.
    // The pipeline is frozen during BUSY, so the hit decision captured at the
    // detection edge is still valid at the ack edge.
    assign w_ack     = (r_state == BUSY) & mem_ack_i;
    assign w_wr_en   = w_ack & ~rst_i & ((r_is_load & r_cacheable) | r_store_hit);
    assign w_wr_data = r_is_load ? mem_rdata_i : r_mem_wdata;

    cache_ram #(
        .SETS       (SETS),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cache_ram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (r_index),
        .i_wr_tag   (r_tag),
        .i_wr_data  (w_wr_data)
    );

    // Stall and load data must respond in the same cycle as the access/ack.
    always_comb begin
        w_stall     = 1'b0;
        w_read_data = '0;
        case (r_state)
            IDLE: begin
                w_stall = w_need_mem;
                if (w_is_load & w_hit) begin
                    w_read_data = w_rd_data;
                end else begin
                    w_read_data = '0;
                end
            end
            BUSY: begin
                w_stall = ~mem_ack_i;
                if (mem_ack_i & r_is_load) begin
                    w_read_data = mem_rdata_i;
                end else begin
                    w_read_data = '0;
                end
            end
            default: begin
                w_stall     = 1'b0;
                w_read_data = '0;
            end
        endcase
    end

    // Controller FSM; also registers the backing-memory request fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_is_load   <= 1'b0;
            r_cacheable <= 1'b0;
            r_store_hit <= 1'b0;
            r_index     <= '0;
            r_tag       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_need_mem) begin
                        r_state     <= BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_is_store;
                        r_mem_addr  <= {alu_resultM_i[ADDRESS_WIDTH-1:BYTE_OFFSET_W],
                                        {BYTE_OFFSET_W{1'b0}}};
                        r_mem_wdata <= write_dataM_i;
                        r_is_load   <= w_is_load;
                        r_cacheable <= cache_weM_i;
                        r_store_hit <= w_is_store & w_hit;
                        r_index     <= w_index;
                        r_tag       <= w_tag;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o      = w_stall;
    assign read_dataM_o = w_read_data;
    assign mem_req_o    = r_mem_req;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
// Self-checking bench for data_cache. A behavioural model (line arrays plus a
// backing-memory map) predicts hit/miss, stall timing, request fields and load
// data for directed scenarios and a randomized access stream.
// -----------------------------------------------------------------------------
module tb_data_cache;

    localparam int SETS = 32;
    localparam int IDXW = 5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] alu_resultM_i;
    logic [31:0] write_dataM_i;
    logic        mem_writeM_i;
    logic        mem_readM_i;
    logic        cache_weM_i;
    logic [31:0] read_dataM_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid [SETS];
    logic [31:0] m_tag   [SETS];
    logic [31:0] m_data  [SETS];
    logic [31:0] bmem    [logic [31:0]];

    always #5 clk_i = ~clk_i;

    data_cache #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .SETS          (SETS)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alu_resultM_i (alu_resultM_i),
        .write_dataM_i (write_dataM_i),
        .mem_writeM_i  (mem_writeM_i),
        .mem_readM_i   (mem_readM_i),
        .cache_weM_i   (cache_weM_i),
        .read_dataM_o  (read_dataM_o),
        .stall_o       (stall_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (bmem.exists(a)) begin
            return bmem[a];
        end else begin
            return a ^ 32'hC0DE_0000;
        end
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic drop_inputs();
        mem_readM_i   = 1'b0;
        mem_writeM_i  = 1'b0;
        cache_weM_i   = 1'b0;
        alu_resultM_i = 32'h0;
        write_dataM_i = 32'h0;
        mem_ack_i     = 1'b0;
        mem_rdata_i   = 32'h0;
    endtask

    // One pipeline access. Entered and left just after a rising edge.
    // lat = number of BUSY cycles before the ack cycle; stray = ack pulse while IDLE.
    task automatic access(input logic rd, input logic wr, input logic c,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int lat, input logic stray);
        logic        is_st, is_ld, hit, need;
        int          idx;
        logic [31:0] tag, waddr, rdata;
        is_st = wr;
        is_ld = rd & ~wr;
        idx   = int'((a >> 2) % SETS);
        tag   = a >> (2 + IDXW);
        hit   = c && is_ld && m_valid[idx] && (m_tag[idx] == tag);
        need  = is_st || (is_ld && !hit);
        waddr = a & 32'hFFFF_FFFC;

        mem_readM_i   = rd;
        mem_writeM_i  = wr;
        cache_weM_i   = c;
        alu_resultM_i = a;
        write_dataM_i = wd;
        mem_ack_i     = stray;
        mem_rdata_i   = $urandom;
        @(negedge clk_i);
        if (!need) begin
            check_eq("hit_stall", {31'b0, stall_o}, 32'h0);
            check_eq("hit_req", {31'b0, mem_req_o}, 32'h0);
            check_eq("hit_data", read_dataM_o, is_ld ? m_data[idx] : 32'h0);
        end else begin
            check_eq("det_stall", {31'b0, stall_o}, 32'h1);
            check_eq("det_req", {31'b0, mem_req_o}, 32'h0);
            check_eq("det_data", read_dataM_o, 32'h0);
            mem_ack_i = 1'b0;
            for (int k = 0; k < lat; k++) begin
                @(posedge clk_i); #1;
                @(negedge clk_i);
                check_eq("busy_req", {31'b0, mem_req_o}, 32'h1);
                check_eq("busy_stall", {31'b0, stall_o}, 32'h1);
                check_eq("busy_we", {31'b0, mem_we_o}, {31'b0, is_st});
                check_eq("busy_addr", mem_addr_o, waddr);
                if (is_st) begin
                    check_eq("busy_wdata", mem_wdata_o, wd);
                end
            end
            @(posedge clk_i); #1;
            rdata       = mem_val(waddr);
            mem_ack_i   = 1'b1;
            mem_rdata_i = is_ld ? rdata : $urandom;
            @(negedge clk_i);
            check_eq("ack_req", {31'b0, mem_req_o}, 32'h1);
            check_eq("ack_we", {31'b0, mem_we_o}, {31'b0, is_st});
            check_eq("ack_addr", mem_addr_o, waddr);
            check_eq("ack_stall", {31'b0, stall_o}, 32'h0);
            check_eq("ack_data", read_dataM_o, is_ld ? rdata : 32'h0);
            if (is_st) begin
                check_eq("ack_wdata", mem_wdata_o, wd);
                bmem[waddr] = wd;
                if (c && m_valid[idx] && m_tag[idx] == tag) begin
                    m_data[idx] = wd;
                end
            end else if (c) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_data[idx]  = rdata;
            end
        end
        @(posedge clk_i); #1;
        drop_inputs();
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        drop_inputs();
        model_clear();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst_req", {31'b0, mem_req_o}, 32'h0);
        check_eq("rst_stall", {31'b0, stall_o}, 32'h0);
        check_eq("rst_data", read_dataM_o, 32'h0);
        @(posedge clk_i); #1;

        // Directed scenarios
        bmem[32'h40] = 32'hDEAD_BEEF;
        access(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 2, 1'b0);          // miss, refill
        access(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 0, 1'b0);          // hit
        check_eq("hit_40", m_data[16], 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 1'b0);  // store hit
        access(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 0, 1'b0);          // hit new data
        access(1'b1, 1'b0, 1'b1, 32'h0000_00C0, 32'h0, 1, 1'b0);          // evicts
        access(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 1, 1'b0);          // miss again
        access(1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 1, 1'b0);          // uncached
        access(1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 2, 1'b0);          // uncached again
        access(1'b1, 1'b0, 1'b1, 32'h0000_0083, 32'h0, 0, 1'b0);          // still a miss
        access(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_0001, 0, 1'b0);  // read+write = store
        access(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 0, 1'b1);          // stray ack in IDLE

        // Reset while BUSY: transaction abandoned, lines invalidated
        mem_readM_i   = 1'b1;
        cache_weM_i   = 1'b0;
        alu_resultM_i = 32'h0000_0200;
        @(negedge clk_i);
        check_eq("rb_det_stall", {31'b0, stall_o}, 32'h1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_eq("rb_busy_req", {31'b0, mem_req_o}, 32'h1);
        @(posedge clk_i); #1;
        drop_inputs();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_clear();
        @(negedge clk_i);
        check_eq("rb_req", {31'b0, mem_req_o}, 32'h0);
        check_eq("rb_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        check_eq("late_ack_stall", {31'b0, stall_o}, 32'h0);
        check_eq("late_ack_req", {31'b0, mem_req_o}, 32'h0);
        check_eq("late_ack_data", read_dataM_o, 32'h0);
        @(posedge clk_i); #1;
        drop_inputs();
        access(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 1, 1'b0);          // must miss

        // Randomized stream over a small address window to mix hits and misses
        for (int n = 0; n < 400; n++) begin
            a    = ($urandom_range(0, 3) << (2 + IDXW)) | ($urandom_range(0, 7) << 2)
                 | $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3, 4: access(1'b1, 1'b0, $urandom_range(0, 4) != 0, a, 32'h0,
                                      $urandom_range(0, 3), $urandom_range(0, 1) == 1);
                5, 6, 7:       access(1'b0, 1'b1, $urandom_range(0, 4) != 0, a, $urandom,
                                      $urandom_range(0, 3), 1'b0);
                8:             access(1'b1, 1'b1, 1'b1, a, $urandom, $urandom_range(0, 3), 1'b0);
                default:       access(1'b0, 1'b0, 1'b1, a, 32'h0, 0, $urandom_range(0, 1) == 1);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
